note_tracker: RTL and testbench

//  Downstream of the FFT peak detector (fftdec). On each note_dec pulse, samples the

---
 rtl/note_pkg.sv | 31 +++
 rtl/note_search.sv | 58 +++++
 rtl/note_tracker.sv | 147 ++++++++++++++
 tb/tb_note_tracker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared constants for the note tracker: semitone boundary ROM, result encoding, FSM states.
package note_pkg;

  localparam int EDGE_N       = 65;
  localparam int MIDI_BASE    = 33;
  localparam int SEARCH_STEPS = 6;

  // EDGE[i] = round(55 * 2^((i - 0.5) / 12)): lower bound of note i, upper bound of note i-1
  localparam logic [11:0] EDGE [0:EDGE_N-1] = '{
    12'd53,   12'd57,   12'd60,   12'd64,   12'd67,   12'd71,   12'd76,   12'd80,
    12'd85,   12'd90,   12'd95,   12'd101,  12'd107,  12'd113,  12'd120,  12'd127,
    12'd135,  12'd143,  12'd151,  12'd160,  12'd170,  12'd180,  12'd190,  12'd202,
    12'd214,  12'd226,  12'd240,  12'd254,  12'd269,  12'd285,  12'd302,  12'd320,
    12'd339,  12'd359,  12'd381,  12'd403,  12'd427,  12'd453,  12'd480,  12'd508,
    12'd539,  12'd571,  12'd605,  12'd640,  12'd679,  12'd719,  12'd762,  12'd807,
    12'd855,  12'd906,  12'd960,  12'd1017, 12'd1077, 12'd1141, 12'd1209, 12'd1281,
    12'd1357, 12'd1438, 12'd1523, 12'd1614, 12'd1710, 12'd1812, 12'd1919, 12'd2033,
    12'd2154
  };

  // Frame result: 0..63 is a note index, 64 means silence / out of range
  localparam logic [6:0] SILENCE = 7'd64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RANGE,
    S_SEARCH,
    S_UPDATE
  } state_t;

endpackage

// File: rtl/note_search.sv
// Range check plus fixed 6-step binary search of a frequency over the boundary ROM.
module note_search
  import note_pkg::*;
#(
  parameter int FREQ_W = 17,
  parameter int NOTE_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [FREQ_W-1:0] f,
  output logic              done,
  output logic [NOTE_W-1:0] idx,
  output logic              oor
);

  logic       active;
  logic [2:0] step;
  logic [6:0] lo;
  logic [6:0] hi;
  logic [6:0] mid;
  logic       ge_mid;
  logic       below;
  logic       above;

  assign mid    = 7'(({1'b0, lo} + {1'b0, hi}) >> 1);
  assign ge_mid = f >= FREQ_W'(EDGE[mid]);
  assign below  = (f == '0) || (f < FREQ_W'(EDGE[0]));
  assign above  = f >= FREQ_W'(EDGE[EDGE_N-1]);
  assign done   = active && (step == 3'(SEARCH_STEPS - 1));
  assign idx    = lo[NOTE_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      step   <= '0;
    end else if (start) begin
      active <= 1'b1;
      step   <= '0;
    end else if (active) begin
      step <= step + 3'd1;
      if (done) active <= 1'b0;
    end
  end

  // Out-of-range frames still run the six step slots untouched, keeping latency constant
  always_ff @(posedge clk) begin
    if (start) begin
      oor <= below || above;
      lo  <= 7'd0;
      hi  <= 7'd64;
    end else if (active && !oor) begin
      if (ge_mid) lo <= mid;
      else        hi <= mid;
    end
  end

endmodule

// File: rtl/note_tracker.sv
// Frame sequencing, debounce across frames, hold timeout and output registers for the note tracker.
module note_tracker
  import note_pkg::*;
#(
  parameter int FREQ_W     = 17,
  parameter int NOTE_W     = 6,
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 4800000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              note_dec,
  input  logic [FREQ_W-1:0] frequency,
  output logic              busy,
  output logic              note_valid,
  output logic [NOTE_W-1:0] note_idx,
  output logic [6:0]        midi_note,
  output logic              note_change,
  output logic              out_of_range
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              start;
  logic [FREQ_W-1:0] f_q;
  logic              srch_done;
  logic [NOTE_W-1:0] srch_idx;
  logic              srch_oor;
  logic [6:0]        result;
  logic [6:0]        cand;
  logic [6:0]        cand_nxt;
  logic [6:0]        held;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              commit;
  logic [TO_W-1:0]   to_cnt;
  logic              timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(STABLE_CNT)) ? CNT_W'(STABLE_CNT) : CNT_W'(c + 1'b1);
  endfunction

  note_search #(
    .FREQ_W(FREQ_W),
    .NOTE_W(NOTE_W)
  ) u_search (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .f    (f_q),
    .done (srch_done),
    .idx  (srch_idx),
    .oor  (srch_oor)
  );

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (note_dec) begin
          accept    = 1'b1;
          state_nxt = S_RANGE;
        end
      end
      S_RANGE: begin
        start     = 1'b1;
        state_nxt = S_SEARCH;
      end
      S_SEARCH: begin
        if (srch_done) state_nxt = S_UPDATE;
      end
      S_UPDATE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Debounce: a result must repeat STABLE_CNT frames before it may replace the held note
  always_comb begin
    result   = srch_oor ? SILENCE : 7'(srch_idx);
    cand_nxt = cand;
    cnt_nxt  = cnt;
    if (result == cand) begin
      cnt_nxt = sat_inc(cnt);
    end else begin
      cand_nxt = result;
      cnt_nxt  = CNT_W'(1);
    end
    held   = note_valid ? 7'(note_idx) : SILENCE;
    commit = (cnt_nxt == CNT_W'(STABLE_CNT)) && (cand_nxt != held);
  end

  assign timeout_hit = !accept && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (accept) f_q <= frequency;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      note_valid   <= 1'b0;
      note_idx     <= '0;
      midi_note    <= '0;
      note_change  <= 1'b0;
      out_of_range <= 1'b0;
      cand         <= SILENCE;
      cnt          <= '0;
      to_cnt       <= '0;
    end else begin
      state       <= state_nxt;
      note_change <= 1'b0;

      if (accept)                         to_cnt <= '0;
      else if (to_cnt != TO_W'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;

      if (state == S_UPDATE) begin
        cand         <= cand_nxt;
        cnt          <= cnt_nxt;
        out_of_range <= srch_oor;
        if (commit) begin
          note_change <= 1'b1;
          if (cand_nxt == SILENCE) begin
            note_valid <= 1'b0;
          end else begin
            note_valid <= 1'b1;
            note_idx   <= cand_nxt[NOTE_W-1:0];
            midi_note  <= 7'(cand_nxt[NOTE_W-1:0]) + 7'(MIDI_BASE);
          end
        end
      end else if (timeout_hit && note_valid) begin
        note_valid  <= 1'b0;
        note_change <= 1'b1;
        cand        <= SILENCE;
        cnt         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_note_tracker.sv
// Directed bench for note_tracker: table of 3-frame vectors plus hand-written corner sequences.
module tb_note_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        note_dec = 1'b0;
  logic [16:0] frequency = '0;
  logic        busy;
  logic        note_valid;
  logic [5:0]  note_idx;
  logic [6:0]  midi_note;
  logic        note_change;
  logic        out_of_range;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [16:0] freq;
    int          valid;
    int          idx;
    int          midi;
    int          oor;
    int          pulses;
  } vec_t;

  vec_t tbl [13];

  note_tracker #(
    .FREQ_W    (17),
    .NOTE_W    (6),
    .STABLE_CNT(3),
    .TIMEOUT   (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .note_dec    (note_dec),
    .frequency   (frequency),
    .busy        (busy),
    .note_valid  (note_valid),
    .note_idx    (note_idx),
    .midi_note   (midi_note),
    .note_change (note_change),
    .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called #1 after a posedge with the tracker idle; returns #1 after edge 9 of the frame.
  task automatic frame(input logic [16:0] f, output int at8, output int stray, output int v7);
    at8   = 0;
    stray = 0;
    v7    = 0;
    note_dec  = 1'b1;
    frequency = f;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) note_dec = 1'b0;
      if (k == 7) v7 = int'(note_valid);
      if (note_change) begin
        if (k == 8) at8++;
        else        stray++;
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},   int'(busy), 0);
    chk({tag, "_valid"},  int'(note_valid), 0);
    chk({tag, "_idx"},    int'(note_idx), 0);
    chk({tag, "_midi"},   int'(midi_note), 0);
    chk({tag, "_change"}, int'(note_change), 0);
    chk({tag, "_oor"},    int'(out_of_range), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, s, a1, s1, v, fall, tp, tpk, saw37;
    logic [16:0] dseq [6];

    tbl[0]  = '{17'd52,   0, 0,  0,  1, 0};
    tbl[1]  = '{17'd2154, 0, 0,  0,  1, 0};
    tbl[2]  = '{17'd0,    0, 0,  0,  1, 0};
    tbl[3]  = '{17'd440,  1, 36, 69, 0, 1};
    tbl[4]  = '{17'd427,  1, 36, 69, 0, 0};
    tbl[5]  = '{17'd426,  1, 35, 68, 0, 1};
    tbl[6]  = '{17'd452,  1, 36, 69, 0, 1};
    tbl[7]  = '{17'd453,  1, 37, 70, 0, 1};
    tbl[8]  = '{17'd53,   1, 0,  33, 0, 1};
    tbl[9]  = '{17'd2153, 1, 63, 96, 0, 1};
    tbl[10] = '{17'd1000, 1, 50, 83, 0, 1};
    tbl[11] = '{17'd440,  1, 36, 69, 0, 1};
    tbl[12] = '{17'd0,    0, 36, 69, 1, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table: each vector applied for three frames, then outputs compared
    for (int i = 0; i < 13; i++) begin
      a = 0;
      s = 0;
      for (int j = 0; j < 3; j++) begin
        frame(tbl[i].freq, a1, s1, v);
        a += a1;
        s += s1;
      end
      chk($sformatf("vec%0d_f%0d_valid", i, tbl[i].freq), int'(note_valid), tbl[i].valid);
      chk($sformatf("vec%0d_f%0d_idx", i, tbl[i].freq), int'(note_idx), tbl[i].idx);
      chk($sformatf("vec%0d_f%0d_midi", i, tbl[i].freq), int'(midi_note), tbl[i].midi);
      chk($sformatf("vec%0d_f%0d_oor", i, tbl[i].freq), int'(out_of_range), tbl[i].oor);
      chk($sformatf("vec%0d_f%0d_pulses", i, tbl[i].freq), a, tbl[i].pulses);
      chk($sformatf("vec%0d_f%0d_stray", i, tbl[i].freq), s, 0);
    end

    // Debounce: interrupted run must restart, 466 never commits
    dseq = '{17'd440, 17'd440, 17'd466, 17'd440, 17'd440, 17'd440};
    a = 0;
    s = 0;
    saw37 = 0;
    for (int j = 0; j < 6; j++) begin
      frame(dseq[j], a1, s1, v);
      a += a1;
      s += s1;
      if (note_valid && note_idx == 6'd37) saw37 = 1;
      if (j == 4) chk("deb_valid_after5", int'(note_valid), 0);
    end
    chk("deb_valid_after6", int'(note_valid), 1);
    chk("deb_idx_after6", int'(note_idx), 36);
    chk("deb_pulses", a, 1);
    chk("deb_stray", s, 0);
    chk("deb_never37", saw37, 0);

    // note_dec while busy is dropped
    a = 0;
    note_dec  = 1'b1;
    frequency = 17'd440;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) note_dec = 1'b0;
      if (k == 2) begin
        chk("busy_during_frame", int'(busy), 1);
        note_dec  = 1'b1;
        frequency = 17'd466;
      end
      if (k == 3) note_dec = 1'b0;
      if (note_change) a++;
    end
    chk("busy_drop_pulses", a, 0);
    chk("busy_drop_idle", int'(busy), 0);
    a = 0;
    for (int j = 0; j < 2; j++) begin
      frame(17'd466, a1, s1, v);
      a += a1 + s1;
    end
    chk("busy_drop_valid", int'(note_valid), 1);
    chk("busy_drop_idx", int'(note_idx), 36);
    chk("busy_drop_pulses2", a, 0);

    // Hold timeout (TIMEOUT=100) counted from the last accepted note_dec
    fall = -1;
    tp = 0;
    tpk = -1;
    note_dec  = 1'b1;
    frequency = 17'd440;
    for (int k = 0; k < 160; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) note_dec = 1'b0;
      if (!note_valid && fall < 0) fall = k;
      if (note_change) begin
        tp++;
        tpk = k;
      end
    end
    chk("timeout_fall_clock", fall, 100);
    chk("timeout_pulse_count", tp, 1);
    chk("timeout_pulse_clock", tpk, 100);

    // Reset asserted mid-search clears outputs without waiting for a clock
    note_dec  = 1'b1;
    frequency = 17'd440;
    @(posedge clk);
    #1;
    note_dec = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midsearch_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_idle", int'(busy), 0);

    // First commit after reset: three 440 Hz frames, pulse 8 clocks after third note_dec
    frame(17'd440, a1, s1, v);
    chk("t1_f1_pulse", a1 + s1, 0);
    frame(17'd440, a1, s1, v);
    chk("t1_f2_pulse", a1 + s1, 0);
    frame(17'd440, a1, s1, v);
    chk("t1_f3_valid_clk7", v, 0);
    chk("t1_f3_pulse_clk8", a1, 1);
    chk("t1_f3_stray", s1, 0);
    chk("t1_valid", int'(note_valid), 1);
    chk("t1_idx", int'(note_idx), 36);
    chk("t1_midi", int'(midi_note), 69);
    chk("t1_oor", int'(out_of_range), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
